// File: rtl/debounce_pkg.sv
// Shared types for the start-button conditioning path.
// Holds the debounce FSM encoding and the default stability window.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } db_state_e;

  // 10 ms at 50 MHz
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for one asynchronous input; latency 2 clk edges.
// Async active-low clear loads RESET_VAL so the output idles at a chosen level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= RESET_VAL;
      q  <= RESET_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/start_debouncer.sv
// Synchronises and debounces the raw start button; one-cycle start pulse per accepted press.
// Press accepted DEBOUNCE_CYCLES+2 edges after first sample; all outputs registered, no backpressure.
module start_debouncer
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic start,
  output logic btn_level,
  output logic busy
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  generate
    if (DEBOUNCE_CYCLES < 2) begin : g_param_check
      $error("start_debouncer: DEBOUNCE_CYCLES must be >= 2");
    end
  endgenerate

  logic             btn_s2;
  logic             btn_sync;
  db_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             start_nxt, level_nxt, busy_nxt;

  // Clearing to the inactive level keeps btn_sync low through reset for either polarity.
  sync_2ff #(
    .RESET_VAL (BTN_ACTIVE_LOW)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (btn_s2)
  );

  assign btn_sync = btn_s2 ^ BTN_ACTIVE_LOW;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      start     <= 1'b0;
      btn_level <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      start     <= start_nxt;
      btn_level <= level_nxt;
      busy      <= busy_nxt;
    end
  end

  // The terminal compare ends each window, so the counter never needs to wrap.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (btn_sync) begin
          state_nxt = DB_PRESS;
          cnt_nxt   = '0;
        end
      end
      DB_PRESS: begin
        if (!btn_sync) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_sync) begin
          state_nxt = DB_RELEASE;
          cnt_nxt   = '0;
        end
      end
      DB_RELEASE: begin
        if (btn_sync) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are precomputed from the transition so they register on the same edge.
  always_comb begin
    start_nxt = (state == DB_PRESS) && (state_nxt == HELD);
    level_nxt = (state_nxt == HELD) || (state_nxt == DB_RELEASE);
    busy_nxt  = (state_nxt == DB_PRESS) || (state_nxt == DB_RELEASE);
  end

endmodule

// File: tb/tb_start_debouncer.sv
// Bench for start_debouncer: active-high and active-low instances driven with mirrored inputs,
// checked every cycle against a run-length reference model plus directed timing checks.
module tb_start_debouncer;

  localparam int N = 4;

  logic clk   = 1'b1;
  logic rst_n = 1'b1;
  logic btn   = 1'b0;
  logic btn_lo;
  logic start_a, level_a, busy_a;
  logic start_b, level_b, busy_b;

  int checks = 0;
  int errors = 0;

  // Reference model: the level flips once the synchronised input has disagreed with it
  // on N+1 consecutive edges (the edge that opens the window plus N counted edges).
  logic m_s0 = 1'b0, m_s1 = 1'b0;
  logic m_level = 1'b0, m_start = 1'b0, m_busy = 1'b0;
  int   m_run = 0;

  logic prev_start_a = 1'b0, prev_start_b = 1'b0;

  assign btn_lo = ~btn;

  always #10 clk = ~clk;

  start_debouncer #(.DEBOUNCE_CYCLES(N), .BTN_ACTIVE_LOW(1'b0)) uut_hi (
    .clk(clk), .reset(rst_n), .btn_in(btn),
    .start(start_a), .btn_level(level_a), .busy(busy_a)
  );

  start_debouncer #(.DEBOUNCE_CYCLES(N), .BTN_ACTIVE_LOW(1'b1)) uut_lo (
    .clk(clk), .reset(rst_n), .btn_in(btn_lo),
    .start(start_b), .btn_level(level_b), .busy(busy_b)
  );

  always @(posedge clk or negedge rst_n) begin : model
    logic seen;
    if (!rst_n) begin
      m_s0 = 1'b0; m_s1 = 1'b0;
      m_level = 1'b0; m_start = 1'b0; m_busy = 1'b0;
      m_run = 0;
    end else begin
      seen = m_s1;
      m_s1 = m_s0;
      m_s0 = btn;
      m_start = 1'b0;
      if (seen != m_level) begin
        m_run++;
        if (m_run == N + 1) begin
          m_level = seen;
          m_start = seen;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
      m_busy = (m_run != 0);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("start_hi", int'(start_a), int'(m_start));
    chk("level_hi", int'(level_a), int'(m_level));
    chk("busy_hi",  int'(busy_a),  int'(m_busy));
    chk("start_lo", int'(start_b), int'(m_start));
    chk("level_lo", int'(level_b), int'(m_level));
    chk("busy_lo",  int'(busy_b),  int'(m_busy));
    if (prev_start_a) chk("start_hi_single", int'(start_a), 0);
    if (prev_start_b) chk("start_lo_single", int'(start_b), 0);
    prev_start_a = start_a;
    prev_start_b = start_b;
  endtask

  initial begin
    int pulse_at, pulse_at_b, fall_at, busy_cnt, pulses, min_level, busy_seen, len;

    // Reset
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_start_hi", int'(start_a), 0);
    chk("rst_level_hi", int'(level_a), 0);
    chk("rst_busy_hi",  int'(busy_a),  0);
    chk("rst_start_lo", int'(start_b), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle out of reset: the active-low instance sees btn_in = 1 and must stay quiet
    repeat (4) tick();
    chk("lo_idle_level", int'(level_b), 0);

    // Clean press
    btn = 1'b1;
    pulse_at = -1; pulse_at_b = -1; busy_cnt = 0; pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (start_a) begin pulses++; if (pulse_at < 0) pulse_at = i; end
      if (start_b && pulse_at_b < 0) pulse_at_b = i;
      if (busy_a && i < 6) busy_cnt++;
    end
    chk("press_pulse_at", pulse_at, N + 2);
    chk("press_pulse_at_lo", pulse_at_b, N + 2);
    chk("press_busy_cycles", busy_cnt, N);
    chk("press_level", int'(level_a), 1);

    // Long hold, then release
    for (int i = 0; i < 80; i++) begin
      tick();
      if (start_a) pulses++;
    end
    chk("hold_pulses", pulses, 1);
    btn = 1'b0;
    fall_at = -1; busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (!level_a && fall_at < 0) fall_at = i;
      if (busy_a) busy_cnt++;
    end
    chk("release_fall_at", fall_at, N + 2);
    chk("release_busy_cycles", busy_cnt, N);

    // Bounce: 1,0,1,0 for two cycles each, then stable high
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      btn = ((i / 2) % 2 == 0);
      tick();
      if (start_a) pulses++;
    end
    chk("bounce_no_pulse", pulses, 0);
    btn = 1'b1;
    pulse_at = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (start_a) begin pulses++; if (pulse_at < 0) pulse_at = i; end
    end
    chk("bounce_pulse_at", pulse_at, N + 2);
    chk("bounce_pulses", pulses, 1);
    btn = 1'b0;
    repeat (12) tick();

    // Re-press during release window
    btn = 1'b1;
    repeat (10) tick();
    chk("repress_first_level", int'(level_a), 1);
    btn = 1'b0;
    pulses = 0; min_level = 1; busy_seen = 0;
    for (int i = 0; i < 22; i++) begin
      if (i == 2) btn = 1'b1;
      tick();
      if (start_a) pulses++;
      if (!level_a) min_level = 0;
      if (busy_a) busy_seen = 1;
    end
    chk("repress_pulses", pulses, 0);
    chk("repress_level_min", min_level, 1);
    chk("repress_busy_seen", busy_seen, 1);
    btn = 1'b0;
    repeat (12) tick();

    // Reset asserted mid-window, button still held at release
    btn = 1'b1;
    repeat (4) tick();
    chk("pre_reset_busy", int'(busy_a), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_start_hi", int'(start_a), 0);
    chk("midrst_level_hi", int'(level_a), 0);
    chk("midrst_busy_hi",  int'(busy_a),  0);
    chk("midrst_busy_lo",  int'(busy_b),  0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prev_start_a = 1'b0; prev_start_b = 1'b0;
    pulse_at = -1; pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (start_a) begin pulses++; if (pulse_at < 0) pulse_at = i; end
    end
    chk("postrst_pulse_at", pulse_at, N + 2);
    chk("postrst_pulses", pulses, 1);
    btn = 1'b0;
    repeat (12) tick();

    // Random bursts of bounce and holds, checked cycle by cycle against the model
    for (int b = 0; b < 80; b++) begin
      btn = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      if ($urandom_range(0, 3) == 0) len = $urandom_range(8, 20);
      repeat (len) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/start_debouncer.md
Name: start_debouncer

Overview:
- Upstream conditioning stage for the `start` input of the state-machine top level (`Top`).
- Takes a raw, asynchronous, bouncing push-button signal.
- Synchronises it to `clk` and debounces it with a stability counter.
- Emits a single-cycle `start` pulse per accepted press, plus a clean debounced level for status/LED use.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronised cycles required to accept a press or release (10 ms at 50 MHz). Legal range ≥ 2; values < 2 are an elaboration error.
- BTN_ACTIVE_LOW, 0, 1 = `btn_in` reads 0 when pressed; the input is inverted after synchronisation.
- CNT_W, $clog2(DEBOUNCE_CYCLES), counter width (derived; not overridden).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- btn_in  input  1  raw button, asynchronous to clk, may bounce
- start  output  1  one-cycle pulse on accepted press; feeds `Top.start`
- btn_level  output  1  debounced button level (1 = pressed)
- busy  output  1  high while a debounce window is counting (DB_PRESS or DB_RELEASE)

Behaviour:
- Reset (reset == 0, asynchronous):
  - Both sync flops cleared (to the inactive level, honouring BTN_ACTIVE_LOW).
  - State = IDLE, counter = 0.
  - start = 0, btn_level = 0, busy = 0.
  - Deassertion takes effect on the next clk edge.
- Synchroniser: 2-flop chain `btn_in` -> s1 -> s2; `btn_sync` = s2, XORed with BTN_ACTIVE_LOW.
- All outputs are registered.
- States: IDLE, DB_PRESS, HELD, DB_RELEASE.
- IDLE:
  - btn_level = 0.
  - btn_sync == 1 -> DB_PRESS, counter cleared to 0.
- DB_PRESS:
  - busy = 1.
  - btn_sync == 0 -> IDLE, counter cleared (glitch rejected, no pulse).
  - Else counter increments.
  - Counter == DEBOUNCE_CYCLES-1 with btn_sync == 1 -> HELD; start = 1 and btn_level = 1 on that same edge.
- HELD:
  - start returns to 0 on the next edge; only one pulse per press, regardless of hold length.
  - btn_sync == 0 -> DB_RELEASE, counter cleared.
- DB_RELEASE:
  - busy = 1; btn_level stays 1.
  - btn_sync == 1 -> HELD, counter cleared, no new pulse.
  - Counter == DEBOUNCE_CYCLES-1 with btn_sync == 0 -> IDLE, btn_level = 0.
- Latency: with k = first clk edge that samples `btn_in` pressed:
  - btn_sync = 1 after edge k+1.
  - DB_PRESS entered at edge k+2.
  - start = 1 after edge k+N+2, where N = DEBOUNCE_CYCLES.
  - start = 0 again after edge k+N+3.
  - Release latency is symmetric: btn_level falls after edge r+N+2.
- Counter:
  - CNT_W bits; saturates-free by construction because the compare terminates the window.
  - Never wraps.
- Boundary conditions:
  - Bounce shorter than N cycles: no state change beyond DB_*; no pulse.
  - Press held indefinitely: exactly one pulse.
  - Re-press during DB_RELEASE: no second pulse.
  - Reset asserted mid-window: immediate return to IDLE; any pulse in flight is dropped.
  - Button held through reset release: after deassertion, the press is treated as new, so a pulse follows N+2 cycles later.
- `start` is never high for more than one consecutive cycle.

Decomposition:
- Package `debounce_pkg`:
  - typedef enum logic [1:0] db_state_e {IDLE, DB_PRESS, HELD, DB_RELEASE}.
  - Localparam for the default DEBOUNCE_CYCLES.
- Sub-module `sync_2ff` (clk, reset, d, q): generic two-flop synchroniser with asynchronous active-low clear, reusable for other async inputs.
- FSM and counter live in `start_debouncer`.

Test Plan:
- Clean press, N=4, clk period 20 ns:
  - Hold reset=0 until 50 ns; btn_in 0->1 sampled at edge k, then held high for 20 cycles.
  - Required: start = 1 only after edge k+6 for exactly one cycle; btn_level rises with it; busy high for the 4-cycle window before it.
- Bounce rejection, N=4:
  - btn_in toggles 1,0,1,0 every 2 cycles, then stays high.
  - Required: no start during toggling; single pulse 6 edges after the final stable high is first sampled.
- Long hold then release, N=4:
  - Press held 100 cycles, then released.
  - Required: exactly one start pulse; btn_level falls after edge r+6; busy high during DB_RELEASE.
- Re-press during release, N=4:
  - Release for 2 cycles, then press again.
  - Required: state returns to HELD; btn_level never drops; no second start.
- Reset mid-debounce, N=4:
  - Assert reset=0 two cycles into DB_PRESS; release reset with btn_in still high.
  - Required: all outputs 0 immediately; new start pulse 6 edges after the first post-reset sampling edge.
- Active-low variant, BTN_ACTIVE_LOW=1, N=4:
  - btn_in idles 1, pressed 0.
  - Required: pulse timing identical to the first scenario; no pulse out of reset with btn_in = 1.
